// File: rtl/sys_display_ctrl.sv
// sys_display_ctrl: formats one DIS request and streams it as ASCII over valid/ready
module sys_display_ctrl #(
  parameter bit HEX_UPPER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic        req_size,
  input  logic [15:0] req_value,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        char_last,
  output logic        busy
);
  localparam logic [2:0] F_C = 3'd0, F_B = 3'd1, F_O = 3'd2, F_D = 3'd3, F_H = 3'd4, F_U = 3'd5;
  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;
  state_t      state;
  logic [2:0]  fmt;
  logic        size;
  logic [15:0] value;
  logic [16:0] work;
  logic [3:0]  dig [5];
  logic        neg;
  logic [2:0]  cnt;
  logic [4:0]  idx;
  logic [4:0]  len;
  logic [4:0]  req_len;
  logic [16:0] sext;
  logic [16:0] mag;
  logic        neg_in;
  logic [4:0]  rpos;
  logic [17:0] oct_src;
  logic [2:0]  od;
  logic [3:0]  nib;
  logic [3:0]  dd;
  logic [2:0]  ms;
  logic [4:0]  msp1;
  logic [7:0]  ch;

  function automatic logic [4:0] fmt_len(input logic [2:0] f, input logic s);
    case (f)
      F_C: return s ? 5'd2 : 5'd1;
      F_B: return s ? 5'd16 : 5'd8;
      F_O: return s ? 5'd6 : 5'd3;
      F_D: return s ? 5'd6 : 5'd4;
      F_H: return s ? 5'd4 : 5'd2;
      F_U: return s ? 5'd5 : 5'd3;
      default: return 5'd0;
    endcase
  endfunction

  assign req_len = fmt_len(req_fmt, req_size);
  assign len = fmt_len(fmt, size);
  assign sext = req_size ? {req_value[15], req_value} : {{9{req_value[7]}}, req_value[7:0]};
  assign neg_in = (req_fmt == F_D) && sext[16];
  // 17-bit negation keeps -32768 representable as a magnitude
  assign mag = neg_in ? 17'd0 - sext : (req_size ? {1'b0, req_value} : {9'd0, req_value[7:0]});
  assign char_data = (state == EMIT) ? ch : 8'h00;

  // Current character, selected by its column weight counted from the right end of the field
  always_comb begin
    ms = 3'd0;
    for (int i = 1; i < 5; i++) if (dig[i] != 4'd0) ms = 3'(i);
    msp1 = {2'b00, ms} + 5'd1;
    rpos = len - idx - 5'd1;
    oct_src = size ? {2'b00, value} : {10'd0, value[7:0]};
    od = 3'(oct_src >> (rpos * 5'd3));
    nib = 4'(value >> {rpos[1:0], 2'b00});
    dd = dig[rpos[2:0]];
    case (fmt)
      F_C: ch = (size && idx == 5'd0) ? value[15:8] : value[7:0];
      F_B: ch = value[rpos[3:0]] ? 8'h31 : 8'h30;
      F_O: ch = 8'h30 + {5'd0, od};
      F_H: ch = (nib < 4'd10) ? 8'h30 + {4'd0, nib} : (HEX_UPPER ? 8'h37 : 8'h57) + {4'd0, nib};
      F_D, F_U: ch = (rpos > msp1) ? 8'h20 : (rpos == msp1) ? (neg ? 8'h2d : 8'h20) : 8'h30 + {4'd0, dd};
      default: ch = 8'h00;
    endcase
  end

  // Request/convert/emit sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b0;
      busy <= 1'b0;
      char_valid <= 1'b0;
      char_last <= 1'b0;
      fmt <= 3'd0;
      size <= 1'b0;
      value <= 16'd0;
      work <= 17'd0;
      neg <= 1'b0;
      cnt <= 3'd0;
      idx <= 5'd0;
      for (int i = 0; i < 5; i++) dig[i] <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready && req_fmt <= F_U) begin
            fmt <= req_fmt;
            size <= req_size;
            value <= req_value;
            work <= mag;
            neg <= neg_in;
            cnt <= 3'd0;
            idx <= 5'd0;
            for (int i = 0; i < 5; i++) dig[i] <= 4'd0;
            req_ready <= 1'b0;
            busy <= 1'b1;
            if (req_fmt == F_D || req_fmt == F_U) state <= CONV;
            else begin
              state <= EMIT;
              char_valid <= 1'b1;
              char_last <= (req_len == 5'd1);
            end
          end
        end
        CONV: begin
          dig[cnt] <= 4'(work % 17'd10);
          work <= work / 17'd10;
          cnt <= cnt + 3'd1;
          if (cnt == (size ? 3'd4 : 3'd2)) begin
            state <= EMIT;
            char_valid <= 1'b1;
            char_last <= 1'b0;
          end
        end
        EMIT: begin
          if (char_ready) begin
            if (char_last) begin
              state <= IDLE;
              char_valid <= 1'b0;
              char_last <= 1'b0;
              busy <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              idx <= idx + 5'd1;
              char_last <= (idx + 5'd2 == len);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_display_ctrl.sv
// tb_sys_display_ctrl: scoreboard bench for the DIS console formatter
module tb_sys_display_ctrl;
  logic        clk, rst_n, req_valid, req_ready, req_size;
  logic        char_valid, char_ready, char_last, busy;
  logic [2:0]  req_fmt;
  logic [15:0] req_value;
  logic [7:0]  char_data;
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  int pass_cnt = 0;
  int total_cnt = 0;

  int          tf [22] = '{4, 1, 2, 2, 5, 5, 5, 3, 3, 3, 0, 0, 4, 4, 1, 2, 5, 3, 3, 3, 3, 3};
  int          tsz [22] = '{1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 1, 0};
  logic [15:0] tv [22] = '{16'h3A7F, 16'h1205, 16'h00FF, 16'hFFFF, 16'h0007, 16'hFFFF, 16'h0000,
                           16'h8000, 16'h00FE, 16'h007F, 16'h4142, 16'h1241, 16'h12AB, 16'hC0DE,
                           16'h8001, 16'h8000, 16'h0100, 16'h7FFF, 16'hFFFF, 16'h0080, 16'h0005, 16'h0000};
  string       ts [22] = '{"3a7f", "00000101", "377", "177777", "  7", "65535", "    0",
                           "-32768", "  -2", " 127", "AB", "A", "ab", "c0de",
                           "1000000000000001", "100000", "  0", " 32767", "    -1", "-128", "     5", "   0"};

  sys_display_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_size(req_size), .req_value(req_value),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .char_last(char_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Push expected chars, present the request and leave at the first negedge after acceptance
  task automatic send(input logic [2:0] f, input logic s, input logic [15:0] v, input string e);
    int n = 0;
    for (int i = 0; i < e.len(); i++) exp_q.push_back(e[i]);
    req_fmt = f;
    req_size = s;
    req_value = v;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL send_ready got=%b want=1", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Gather chars until char_last; lat counts negedges after the accepting edge
  task automatic collect(output int lat, output bit rdy_after, output bit tmo);
    got_q.delete();
    lat = 0;
    tmo = 1'b1;
    rdy_after = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (char_valid === 1'b1) begin
        if (got_q.size() == 0) lat = cyc;
        got_q.push_back(char_data);
        if (char_last === 1'b1) begin
          @(negedge clk);
          rdy_after = req_ready;
          tmo = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b0 || char_valid !== 1'b0 || char_data !== 8'h00 || char_last !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_outputs ready=%b valid=%b data=%h last=%b busy=%b want 0/0/00/0/0",
               req_ready, char_valid, char_data, char_last, busy);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release ready=%b busy=%b want 1/0", req_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_formats();
    int lat, el, want_lat;
    bit rdy, tmo;
    logic [7:0] e, g;
    for (int k = 0; k < 22; k++) begin
      el = ts[k].len();
      want_lat = (tf[k] == 3 || tf[k] == 5) ? (tsz[k] != 0 ? 6 : 4) : 1;
      send(3'(tf[k]), 1'(tsz[k]), tv[k], ts[k]);
      collect(lat, rdy, tmo);
      total_cnt++;
      if (tmo || got_q.size() != el)
        $display("FAIL fmt_len case%0d got=%0d want=%0d timeout=%b", k, got_q.size(), el, tmo);
      else pass_cnt++;
      for (int i = 0; i < el; i++) begin
        e = exp_q.pop_front();
        g = (i < got_q.size()) ? got_q[i] : 8'h00;
        total_cnt++;
        if (g !== e) $display("FAIL fmt_char case%0d pos%0d got=%h want=%h", k, i, g, e);
        else pass_cnt++;
      end
      total_cnt++;
      if (lat != want_lat) $display("FAIL fmt_latency case%0d got=%0d want=%0d", k, lat, want_lat);
      else pass_cnt++;
      total_cnt++;
      if (rdy !== 1'b1) $display("FAIL fmt_ready_after case%0d got=%b want=1", k, rdy);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit rdy, tmo;
    logic [7:0] e, g;
    send(3'd0, 1'b1, 16'h4142, "AB");
    char_ready = 1'b0;
    req_fmt = 3'd4;
    req_size = 1'b1;
    req_value = 16'h5555;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if (char_valid !== 1'b1 || char_data !== 8'h41 || char_last !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL stall cyc%0d valid=%b data=%h last=%b ready=%b busy=%b want 1/41/0/0/1",
                 c, char_valid, char_data, char_last, req_ready, busy);
      else pass_cnt++;
      @(negedge clk);
    end
    char_ready = 1'b1;
    collect(lat, rdy, tmo);
    req_valid = 1'b0;
    total_cnt++;
    if (tmo || got_q.size() != 2) $display("FAIL stall_len got=%0d want=2 timeout=%b", got_q.size(), tmo);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : 8'h00;
      total_cnt++;
      if (g !== e) $display("FAIL stall_char pos%0d got=%h want=%h", i, g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (rdy !== 1'b1) $display("FAIL stall_ready_after got=%b want=1", rdy);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total_cnt++;
      if (char_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL emit_req_ignored cyc%0d valid=%b busy=%b want 0/0", c, char_valid, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_reserved();
    for (int f = 6; f < 8; f++) begin
      send(3'(f), 1'b1, 16'h4141, "");
      for (int c = 0; c < 3; c++) begin
        total_cnt++;
        if (req_ready !== 1'b1 || char_valid !== 1'b0 || busy !== 1'b0)
          $display("FAIL reserved fmt%0d cyc%0d ready=%b valid=%b busy=%b want 1/0/0", f, c, req_ready, char_valid, busy);
        else pass_cnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] e;
    send(3'd4, 1'b1, 16'hBEEF, "be");
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (char_valid !== 1'b1 || char_data !== e)
        $display("FAIL abort_char pos%0d valid=%b data=%h want 1/%h", i, char_valid, char_data, e);
      else pass_cnt++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (char_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || char_data !== 8'h00 || char_last !== 1'b0)
      $display("FAIL abort_reset valid=%b busy=%b ready=%b data=%h last=%b want 0/0/0/00/0",
               char_valid, busy, req_ready, char_data, char_last);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL abort_release ready=%b want 1", req_ready);
    else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total_cnt++;
      if (char_valid !== 1'b0 || busy !== 1'b0) $display("FAIL abort_quiet cyc%0d valid=%b busy=%b want 0/0", c, char_valid, busy);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_fmt = 3'd0;
    req_size = 1'b0;
    req_value = 16'h0000;
    char_ready = 1'b1;
    test_reset();
    test_formats();
    test_backpressure();
    test_reserved();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
